// File: rtl/control_unit_if.sv
// Instruction handshake and datapath control bundle between the sequencer
// (master side, owns the instruction stream and ALU status) and control_unit.
interface control_unit_if #(
  parameter int WORDSIZE = 64
);
  logic                cu_instr_valid;
  logic [31:0]         cu_instruction;
  logic                cu_alu_zero;
  logic                cu_instr_ready;
  logic [4:0]          cu_rf_addr_a;
  logic [4:0]          cu_rf_addr_b;
  logic [4:0]          cu_rf_write_addr;
  logic                cu_rf_write_en;
  logic [WORDSIZE-1:0] cu_immediate;
  logic                cu_mux_0_sel;
  logic                cu_mux_1_sel;
  logic                cu_mux_2_sel;
  logic [2:0]          cu_alu_operation;
  logic                cu_dm_write_en;
  logic                cu_branch_taken;
  logic                cu_illegal;

  modport master (
    output cu_instr_valid, cu_instruction, cu_alu_zero,
    input  cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
           cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
           cu_mux_2_sel, cu_alu_operation, cu_dm_write_en, cu_branch_taken,
           cu_illegal
  );

  modport slave (
    input  cu_instr_valid, cu_instruction, cu_alu_zero,
    output cu_instr_ready, cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
           cu_rf_write_en, cu_immediate, cu_mux_0_sel, cu_mux_1_sel,
           cu_mux_2_sel, cu_alu_operation, cu_dm_write_en, cu_branch_taken,
           cu_illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle RV64I subset control unit (ld, sd, addi, add, sub, and, or, beq).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | ready for an instruction; captures it on valid
// DECODE    | fields/selects registered; illegal encodings bail out here
// EXECUTE   | ALU works on registered operands; beq outcome sampled
// MEMORY    | data-memory access (ld read, sd write strobe)
// WRITEBACK | register-file write strobe (suppressed for rd = x0)
//
// All outputs are registered. The instruction class is decided at accept so
// that cu_illegal can be presented during the DECODE cycle itself.
module control_unit #(
  parameter int WORDSIZE = 64
) (
  input  logic        cu_clk,
  input  logic        cu_rst_n,
  control_unit_if.slave cu_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK
  } state_t;

  typedef enum logic [2:0] {
    K_LD,
    K_SD,
    K_ADDI,
    K_RTYPE,
    K_BEQ,
    K_ILLEGAL
  } kind_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  state_t      state;
  kind_t       kind_q;
  logic [2:0]  op_q;
  logic [31:15] hi_q;
  logic [11:7] rd_q;

  kind_t       kind_in;
  logic [2:0]  op_in;
  logic [31:0] ins_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [WORDSIZE-1:0] imm_i;
  logic [WORDSIZE-1:0] imm_s;
  logic [WORDSIZE-1:0] imm_b;

  logic                ready_r;
  logic [4:0]          addr_a_r;
  logic [4:0]          addr_b_r;
  logic [4:0]          write_addr_r;
  logic                rf_we_r;
  logic [WORDSIZE-1:0] imm_r;
  logic                mux_0_r;
  logic                mux_1_r;
  logic                mux_2_r;
  logic [2:0]          alu_op_r;
  logic                dm_we_r;
  logic                branch_r;
  logic                illegal_r;

  function automatic logic [WORDSIZE-1:0] sext12(input logic [11:0] v);
    return {{(WORDSIZE-12){v[11]}}, v};
  endfunction

  function automatic logic [WORDSIZE-1:0] sext13(input logic [12:0] v);
    return {{(WORDSIZE-13){v[12]}}, v};
  endfunction

  // Classify the incoming instruction word and pick the R-type ALU op.
  always_comb begin
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc     = cu_bus.cu_instruction[6:0];
    f3      = cu_bus.cu_instruction[14:12];
    f7      = cu_bus.cu_instruction[31:25];
    kind_in = K_ILLEGAL;
    op_in   = OP_ADD;
    case (opc)
      7'b0000011: if (f3 == 3'b011) kind_in = K_LD;
      7'b0100011: if (f3 == 3'b011) kind_in = K_SD;
      7'b0010011: if (f3 == 3'b000) kind_in = K_ADDI;
      7'b1100011: if (f3 == 3'b000) kind_in = K_BEQ;
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000: begin kind_in = K_RTYPE; op_in = OP_ADD; end
            3'b111: begin kind_in = K_RTYPE; op_in = OP_AND; end
            3'b110: begin kind_in = K_RTYPE; op_in = OP_OR;  end
            default: kind_in = K_ILLEGAL;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          kind_in = K_RTYPE;
          op_in   = OP_SUB;
        end
      end
      default: kind_in = K_ILLEGAL;
    endcase
  end

  // Rebuild the captured word (opcode/funct3 are already folded into kind_q)
  // and derive register indices and the three immediate formats.
  always_comb begin
    ins_q = {hi_q, 3'b000, rd_q, 7'b0000000};
    rs1_q = ins_q[19:15];
    rs2_q = ins_q[24:20];
    imm_i = sext12(ins_q[31:20]);
    imm_s = sext12({ins_q[31:25], ins_q[11:7]});
    imm_b = sext13({ins_q[31], ins_q[7], ins_q[30:25], ins_q[11:8], 1'b0});
  end

  // Sequencer FSM with registered control outputs; strobes default low.
  always_ff @(posedge cu_clk or negedge cu_rst_n) begin
    if (!cu_rst_n) begin
      state        <= S_IDLE;
      kind_q       <= K_ILLEGAL;
      op_q         <= OP_ADD;
      hi_q         <= '0;
      rd_q         <= '0;
      ready_r      <= 1'b1;
      addr_a_r     <= '0;
      addr_b_r     <= '0;
      write_addr_r <= '0;
      rf_we_r      <= 1'b0;
      imm_r        <= '0;
      mux_0_r      <= 1'b0;
      mux_1_r      <= 1'b0;
      mux_2_r      <= 1'b0;
      alu_op_r     <= OP_ADD;
      dm_we_r      <= 1'b0;
      branch_r     <= 1'b0;
      illegal_r    <= 1'b0;
    end else begin
      rf_we_r   <= 1'b0;
      dm_we_r   <= 1'b0;
      branch_r  <= 1'b0;
      illegal_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cu_bus.cu_instr_valid) begin
            kind_q    <= kind_in;
            op_q      <= op_in;
            hi_q      <= cu_bus.cu_instruction[31:15];
            rd_q      <= cu_bus.cu_instruction[11:7];
            illegal_r <= (kind_in == K_ILLEGAL);
            ready_r   <= 1'b0;
            state     <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXECUTE;
          case (kind_q)
            K_LD, K_ADDI: begin
              addr_a_r     <= rs1_q;
              addr_b_r     <= '0;
              write_addr_r <= rd_q;
              imm_r        <= imm_i;
              mux_0_r      <= 1'b0;
              mux_1_r      <= 1'b0;
              mux_2_r      <= (kind_q == K_LD);
              alu_op_r     <= OP_ADD;
            end
            K_SD: begin
              addr_a_r     <= rs2_q;
              addr_b_r     <= rs1_q;
              write_addr_r <= '0;
              imm_r        <= imm_s;
              mux_0_r      <= 1'b1;
              mux_1_r      <= 1'b0;
              mux_2_r      <= 1'b0;
              alu_op_r     <= OP_ADD;
            end
            K_RTYPE: begin
              addr_a_r     <= rs1_q;
              addr_b_r     <= rs2_q;
              write_addr_r <= rd_q;
              imm_r        <= '0;
              mux_0_r      <= 1'b0;
              mux_1_r      <= 1'b1;
              mux_2_r      <= 1'b0;
              alu_op_r     <= op_q;
            end
            K_BEQ: begin
              addr_a_r     <= rs1_q;
              addr_b_r     <= rs2_q;
              write_addr_r <= '0;
              imm_r        <= imm_b;
              mux_0_r      <= 1'b0;
              mux_1_r      <= 1'b1;
              mux_2_r      <= 1'b0;
              alu_op_r     <= OP_SUB;
            end
            default: begin
              state   <= S_IDLE;
              ready_r <= 1'b1;
            end
          endcase
        end
        S_EXECUTE: begin
          case (kind_q)
            K_LD, K_SD: begin
              state   <= S_MEMORY;
              dm_we_r <= (kind_q == K_SD);
            end
            K_RTYPE, K_ADDI: begin
              state   <= S_WRITEBACK;
              rf_we_r <= (write_addr_r != 5'd0);
            end
            default: begin
              // beq resolves here; the outcome shows during the next cycle
              branch_r <= (kind_q == K_BEQ) && cu_bus.cu_alu_zero;
              state    <= S_IDLE;
              ready_r  <= 1'b1;
            end
          endcase
        end
        S_MEMORY: begin
          if (kind_q == K_LD) begin
            state   <= S_WRITEBACK;
            rf_we_r <= (write_addr_r != 5'd0);
          end else begin
            state   <= S_IDLE;
            ready_r <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign cu_bus.cu_instr_ready   = ready_r;
  assign cu_bus.cu_rf_addr_a     = addr_a_r;
  assign cu_bus.cu_rf_addr_b     = addr_b_r;
  assign cu_bus.cu_rf_write_addr = write_addr_r;
  assign cu_bus.cu_rf_write_en   = rf_we_r;
  assign cu_bus.cu_immediate     = imm_r;
  assign cu_bus.cu_mux_0_sel     = mux_0_r;
  assign cu_bus.cu_mux_1_sel     = mux_1_r;
  assign cu_bus.cu_mux_2_sel     = mux_2_r;
  assign cu_bus.cu_alu_operation = alu_op_r;
  assign cu_bus.cu_dm_write_en   = dm_we_r;
  assign cu_bus.cu_branch_taken  = branch_r;
  assign cu_bus.cu_illegal       = illegal_r;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: one linear sequence of instructions with
// hand-computed expectations, checked cycle by cycle after each rising edge.
module tb_control_unit;

  localparam int WS = 64;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   seen;

  control_unit_if #(.WORDSIZE(WS)) bus ();

  control_unit #(.WORDSIZE(WS)) dut (
    .cu_clk   (clk),
    .cu_rst_n (rst_n),
    .cu_bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] ins);
    bus.cu_instr_valid = 1'b1;
    bus.cu_instruction = ins;
    step();
    bus.cu_instr_valid = 1'b0;
  endtask

  task automatic check_strobes_low(input string tag);
    check({tag, "_rfwe"}, 64'(bus.cu_rf_write_en), 64'd0);
    check({tag, "_dmwe"}, 64'(bus.cu_dm_write_en), 64'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.cu_instr_valid = 1'b0;
    bus.cu_instruction = 32'h0;
    bus.cu_alu_zero    = 1'b0;
    #12;
    // reset state
    check("rst_ready", 64'(bus.cu_instr_ready), 64'd1);
    check("rst_imm",   bus.cu_immediate, 64'd0);
    check("rst_addra", 64'(bus.cu_rf_addr_a), 64'd0);
    check("rst_mux2",  64'(bus.cu_mux_2_sel), 64'd0);
    check("rst_illeg", 64'(bus.cu_illegal), 64'd0);
    check_strobes_low("rst");
    #10 rst_n = 1'b1;
    step();

    // ld x2,5(x7)
    accept(32'h0053B103);
    check("ld_c1_ready", 64'(bus.cu_instr_ready), 64'd0);
    check_strobes_low("ld_c1");
    step();
    check("ld_addra", 64'(bus.cu_rf_addr_a), 64'd7);
    check("ld_imm",   bus.cu_immediate, 64'd5);
    check("ld_mux",   {61'd0, bus.cu_mux_0_sel, bus.cu_mux_1_sel, bus.cu_mux_2_sel}, 64'b001);
    check("ld_op",    64'(bus.cu_alu_operation), 64'd0);
    check_strobes_low("ld_c2");
    step();
    check_strobes_low("ld_c3");
    step();
    check("ld_c4_rfwe",  64'(bus.cu_rf_write_en), 64'd1);
    check("ld_c4_waddr", 64'(bus.cu_rf_write_addr), 64'd2);
    check("ld_c4_ready", 64'(bus.cu_instr_ready), 64'd0);
    step();
    check("ld_c5_ready", 64'(bus.cu_instr_ready), 64'd1);
    check_strobes_low("ld_c5");

    // sd x4,23(x2)
    accept(32'h00413BA3);
    check_strobes_low("sd_c1");
    step();
    check("sd_addra", 64'(bus.cu_rf_addr_a), 64'd4);
    check("sd_addrb", 64'(bus.cu_rf_addr_b), 64'd2);
    check("sd_imm",   bus.cu_immediate, 64'h17);
    check("sd_mux01", {62'd0, bus.cu_mux_0_sel, bus.cu_mux_1_sel}, 64'b10);
    check_strobes_low("sd_c2");
    step();
    check("sd_c3_dmwe", 64'(bus.cu_dm_write_en), 64'd1);
    check("sd_c3_rfwe", 64'(bus.cu_rf_write_en), 64'd0);
    step();
    check("sd_c4_ready", 64'(bus.cu_instr_ready), 64'd1);
    check_strobes_low("sd_c4");

    // add x3,x1,x2 with addi x0,x0,1 held valid right behind it
    accept(32'h002081B3);
    bus.cu_instr_valid = 1'b1;
    bus.cu_instruction = 32'h00100013;
    check("add_c1_ready", 64'(bus.cu_instr_ready), 64'd0);
    step();
    check("add_addra", 64'(bus.cu_rf_addr_a), 64'd1);
    check("add_addrb", 64'(bus.cu_rf_addr_b), 64'd2);
    check("add_mux1",  64'(bus.cu_mux_1_sel), 64'd1);
    check("add_op",    64'(bus.cu_alu_operation), 64'd0);
    check("add_c2_ready", 64'(bus.cu_instr_ready), 64'd0);
    step();
    check("add_c3_rfwe",  64'(bus.cu_rf_write_en), 64'd1);
    check("add_c3_waddr", 64'(bus.cu_rf_write_addr), 64'd3);
    step();
    check("add_c4_ready", 64'(bus.cu_instr_ready), 64'd1);
    check("add_c4_rfwe",  64'(bus.cu_rf_write_en), 64'd0);
    step();
    bus.cu_instr_valid = 1'b0;
    check("addi_acc_ready", 64'(bus.cu_instr_ready), 64'd0);
    step();
    check("addi_waddr", 64'(bus.cu_rf_write_addr), 64'd0);
    check("addi_imm",   bus.cu_immediate, 64'd1);
    check("addi_mux1",  64'(bus.cu_mux_1_sel), 64'd0);
    step();
    check("addi_c3_rfwe", 64'(bus.cu_rf_write_en), 64'd0);
    step();
    check("addi_c4_ready", 64'(bus.cu_instr_ready), 64'd1);
    step();
    check("addi_once_ready", 64'(bus.cu_instr_ready), 64'd1);

    // beq x1,x1,+8 taken
    bus.cu_alu_zero = 1'b1;
    accept(32'h00108463);
    check("beq1_c1_br", 64'(bus.cu_branch_taken), 64'd0);
    step();
    check("beq1_op",  64'(bus.cu_alu_operation), 64'd1);
    check("beq1_imm", bus.cu_immediate, 64'd8);
    check("beq1_ab",  {54'd0, bus.cu_rf_addr_a, bus.cu_rf_addr_b}, {54'd0, 5'd1, 5'd1});
    check("beq1_c2_br", 64'(bus.cu_branch_taken), 64'd0);
    step();
    check("beq1_c3_br",    64'(bus.cu_branch_taken), 64'd1);
    check("beq1_c3_ready", 64'(bus.cu_instr_ready), 64'd1);
    check_strobes_low("beq1_c3");
    step();
    check("beq1_c4_br", 64'(bus.cu_branch_taken), 64'd0);

    // beq not taken
    bus.cu_alu_zero = 1'b0;
    accept(32'h00108463);
    step();
    step();
    check("beq0_c3_br",    64'(bus.cu_branch_taken), 64'd0);
    check("beq0_c3_ready", 64'(bus.cu_instr_ready), 64'd1);

    // illegal encoding
    accept(32'hFFFFFFFF);
    check("ill_c1_pulse", 64'(bus.cu_illegal), 64'd1);
    check("ill_c1_ready", 64'(bus.cu_instr_ready), 64'd0);
    check_strobes_low("ill_c1");
    step();
    check("ill_c2_pulse", 64'(bus.cu_illegal), 64'd0);
    check("ill_c2_ready", 64'(bus.cu_instr_ready), 64'd1);
    check_strobes_low("ill_c2");

    // sub with funct7 on and (funct3 111) is not a legal encoding
    accept(32'h4020F1B3);
    check("ill2_pulse", 64'(bus.cu_illegal), 64'd1);
    step();

    // reset during ld MEMORY
    accept(32'h0053B103);
    step();
    step();
    check("rld_mux2_pre", 64'(bus.cu_mux_2_sel), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rld_ready", 64'(bus.cu_instr_ready), 64'd1);
    check("rld_imm",   bus.cu_immediate, 64'd0);
    check("rld_addra", 64'(bus.cu_rf_addr_a), 64'd0);
    check("rld_mux2",  64'(bus.cu_mux_2_sel), 64'd0);
    check_strobes_low("rld");
    step();
    #3 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.cu_rf_write_en) seen++;
    end
    check("rld_no_wb", 64'(seen), 64'd0);
    check("rld_ready_after", 64'(bus.cu_instr_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have parameter WORDSIZE, default 64, giving the width of the generated immediate.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset, with ports named cu_clk and cu_rst_n.
REQ-003 cu_clk  input  1  rising-edge clock.
REQ-004 cu_rst_n  input  1  asynchronous active-low reset.
REQ-005 cu_instr_valid  input  1  cu_instruction holds a valid instruction.
REQ-006 cu_instruction  input  32  RV64I instruction word.
REQ-007 cu_alu_zero  input  1  datapath ALU result equals zero.
REQ-008 cu_instr_ready  output  1  block can accept an instruction.
REQ-009 cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr  output  5 each  register-file addresses.
REQ-010 cu_rf_write_en  output  1  register-file write strobe.
REQ-011 cu_immediate  output  WORDSIZE  sign-extended immediate.
REQ-012 cu_mux_0_sel  output  1  ALU operand A source: 0 = rf data a, 1 = rf data b.
REQ-013 cu_mux_1_sel  output  1  ALU operand B source: 0 = immediate, 1 = rf data b.
REQ-014 cu_mux_2_sel  output  1  write-back source: 0 = ALU result, 1 = data-memory output.
REQ-015 cu_alu_operation  output  3  ALU op: 000 add, 001 sub, 010 and, 011 or.
REQ-016 cu_dm_write_en  output  1  data-memory write strobe.
REQ-017 cu_branch_taken  output  1  one-cycle pulse for a taken beq.
REQ-018 cu_illegal  output  1  one-cycle pulse for an unsupported instruction.

Function
REQ-019 The block SHALL be a registered FSM with states IDLE, DECODE, EXECUTE, MEMORY and WRITEBACK.
REQ-020 cu_instr_ready SHALL be 1 only in IDLE; the instruction SHALL be captured on the edge where cu_instr_valid && cu_instr_ready, and the next state SHALL be DECODE.
REQ-021 The supported instructions SHALL be:
- ld (opcode 0000011, funct3 011)
- sd (opcode 0100011, funct3 011)
- addi (opcode 0010011, funct3 000)
- add/sub (opcode 0110011, funct3 000, funct7 0000000 / 0100000)
- and (funct3 111, funct7 0000000)
- or (funct3 110, funct7 0000000)
- beq (opcode 1100011, funct3 000)
REQ-022 Any other encoding SHALL pulse cu_illegal for the DECODE cycle, assert no write strobe, and return to IDLE.
REQ-023 In DECODE the block SHALL register the addresses, the immediate, the mux selects and the ALU op; these SHALL hold stable until the block returns to IDLE.
REQ-024 ld and addi SHALL drive: addr_a = rs1, mux_0 = 0, mux_1 = 0, op = add, write_addr = rd. ld SHALL also drive mux_2 = 1; addi SHALL drive mux_2 = 0.
REQ-025 sd SHALL drive: addr_a = rs2 (store data), addr_b = rs1 (base), mux_0 = 1, mux_1 = 0, op = add.
REQ-026 R-type instructions SHALL drive: addr_a = rs1, addr_b = rs2, mux_0 = 0, mux_1 = 1, mux_2 = 0, write_addr = rd.
REQ-027 beq SHALL drive: addr_a = rs1, addr_b = rs2, mux_0 = 0, mux_1 = 1, op = sub.
REQ-028 Immediates SHALL be sign-extended to WORDSIZE:
- I-type: instr[31:20]
- S-type: {instr[31:25], instr[11:7]}
- B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
REQ-029 State paths SHALL be:
- R-type/addi: DECODE→EXECUTE→WRITEBACK→IDLE
- ld: DECODE→EXECUTE→MEMORY→WRITEBACK→IDLE
- sd: DECODE→EXECUTE→MEMORY→IDLE
- beq: DECODE→EXECUTE→IDLE
REQ-030 cu_rf_write_en SHALL be 1 for exactly the WRITEBACK cycle, and SHALL be forced 0 when rd = x0.
REQ-031 cu_dm_write_en SHALL be 1 for exactly the MEMORY cycle of sd, and 0 at all other times.
REQ-032 cu_branch_taken SHALL equal cu_alu_zero sampled during beq's EXECUTE cycle, pulsed for the following cycle only.
REQ-033 The block SHALL ignore cu_instr_valid outside IDLE; no instruction SHALL be lost or double-accepted.
REQ-034 Accept-to-ready latency SHALL be: 4 cycles (R/addi), 5 (ld), 4 (sd), 3 (beq), 2 (illegal).

Reset
REQ-035 While cu_rst_n = 0, the FSM SHALL be in IDLE and every output SHALL be 0 except cu_instr_ready = 1; strobes SHALL drop immediately without waiting for a clock edge.
REQ-036 Reset asserted mid-instruction SHALL abandon that instruction, and no write strobe SHALL occur after cu_rst_n rises.

Verification
REQ-037 ld x2,5(x7) = 0x0053B103 → addr_a = 7, imm = 5, mux_0/1/2 = 0/0/1, op = 000, rf_write_en pulse to addr 2 on the 4th cycle after accept, ready again on the 5th.
REQ-038 sd x4,23(x2) = 0x00413BA3 → addr_a = 4, addr_b = 2, imm = 0x17, mux_0 = 1, mux_1 = 0, single dm_write_en pulse, rf_write_en never asserted.
REQ-039 add x3,x1,x2 = 0x002081B3 then back-to-back valid addi x0,x0,1 = 0x00100013 → add writes x3 (mux_1 = 1, op = 000); addi is accepted only when ready and produces no rf_write_en.
REQ-040 beq x1,x1,+8 = 0x00108463 with cu_alu_zero = 1 → op = 001, imm = 8, one-cycle branch_taken; repeat with cu_alu_zero = 0 → no pulse.
REQ-041 0xFFFFFFFF → one-cycle cu_illegal, no strobes, ready after 2 cycles.
REQ-042 Reset pulled low during ld's MEMORY state → outputs zero immediately with ready = 1, and no rf_write_en pulse after release.
